// File: rtl/an_frame_corrector_if.sv
// Stream interface for an_frame_corrector.
//   in_valid/in_ready/in_cw        : codeword input channel (one codeword per beat)
//   out_valid/out_ready/out_msg    : decoded message output channel
//   out_corr/out_uncorr/out_last   : per-message status and end-of-frame marker
// master: the environment side (drives codewords, accepts messages).
// slave : the corrector side.
interface an_frame_corrector_if #(
  parameter int unsigned CW_W  = 14,
  parameter int unsigned MSG_W = 10
);
  logic             in_valid;
  logic             in_ready;
  logic [CW_W-1:0]  in_cw;
  logic             out_valid;
  logic             out_ready;
  logic [MSG_W-1:0] out_msg;
  logic             out_corr;
  logic             out_uncorr;
  logic             out_last;

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_msg, out_corr, out_uncorr, out_last
  );

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_msg, out_corr, out_uncorr, out_last
  );
endinterface

// File: rtl/an_frame_corrector.sv
// AN-code frame corrector. Buffers a ROWS x COLS frame of AN codewords (cw = A*msg), computes
// Barrett residues on load, repairs single-bit flips by an iterative bit search (at most MAX_CORR
// cells per frame), then streams out the decoded messages in raster order.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : codeword input stream and message output stream with status flags
//   row_err, col_err  : cells with non-zero residue in the current frame, held until next load
//   stat_corr/uncorr  : (AN_CORR_STATS_EN only) saturating counts of corrected/uncorrectable
//                       messages accepted at the output
// Optional feature macro: AN_CORR_STATS_EN.
module an_frame_corrector #(
  parameter int unsigned A        = 29,
  parameter int unsigned CW_W     = 14,
  parameter int unsigned MSG_W    = 10,
  parameter int unsigned K        = 28,
  parameter int unsigned MU       = 9256395,
  parameter int unsigned ROWS     = 5,
  parameter int unsigned COLS     = 5,
  parameter int unsigned MAX_CORR = 25
) (
  input  logic                   clk,
  input  logic                   rst,
  an_frame_corrector_if.slave    bus,
  output logic [ROWS-1:0]        row_err,
  output logic [COLS-1:0]        col_err
`ifdef AN_CORR_STATS_EN
  ,
  output logic [15:0]            stat_corr,
  output logic [15:0]            stat_uncorr
`endif
);

  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned RW   = $clog2(A);
  localparam int unsigned BitW = (CW_W > 1) ? $clog2(CW_W) : 1;
  localparam int unsigned CntW = $clog2(MAX_CORR + 1);
  localparam int unsigned PW   = CW_W + K + 1;

  typedef enum logic [1:0] {StLoad, StScan, StSearch, StDrain} state_e;

  // Returns {q, r} with cw = q*A + r, 0 <= r < A.
  function automatic logic [CW_W+RW-1:0] barrett(input logic [CW_W-1:0] cw);
    logic [PW-1:0]   prod;
    logic [CW_W-1:0] qe;
    logic [CW_W-1:0] rx;
    prod = PW'(cw) * PW'(MU);
    qe   = CW_W'(prod >> K);
    rx   = cw - qe * CW_W'(A);
    if (rx >= CW_W'(A)) begin
      qe = qe + CW_W'(1);
      rx = rx - CW_W'(A);
    end
    return {qe, RW'(rx)};
  endfunction

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [RowW-1:0]   row_q, row_d;
  logic [ColW-1:0]   col_q, col_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [RW-1:0]     p_q, p_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0]   row_err_q, row_err_d;
  logic [COLS-1:0]   col_err_q, col_err_d;

  logic [CW_W-1:0]   cw_mem [N];
  logic [RW-1:0]     r_mem  [N];
  logic [N-1:0]      corr_mem, uncorr_mem;

  logic              load_we, fix_we, mark_corr, mark_uncorr, adv;
  logic [CW_W-1:0]   cur_cw, fix_cw, bq_in, bq_q;
  logic [RW-1:0]     cur_r, bq_r, p_next;
  logic [RW:0]       p2;
  logic              last_idx, match, q_ovf;

  // One Barrett unit shared between load (residue of the incoming word) and drain (quotient).
  assign bq_in         = (state_q == StDrain) ? cw_mem[idx_q] : bus.in_cw;
  assign {bq_q, bq_r}  = barrett(bq_in);
  assign q_ovf         = (bq_q >> MSG_W) != '0;

  assign cur_cw   = cw_mem[idx_q];
  assign cur_r    = r_mem[idx_q];
  assign last_idx = idx_q == IdxW'(N - 1);
  assign fix_cw   = cur_cw ^ (CW_W'(1) << bit_q);

  // p tracks 2^bit mod A. A set bit flipped in adds p to the residue; a cleared bit subtracts p.
  assign p2     = {p_q, 1'b0};
  assign p_next = (p2 >= (RW + 1)'(A)) ? RW'(p2 - (RW + 1)'(A)) : RW'(p2);
  assign match  = cur_cw[bit_q] ? (p_q == cur_r) : ((RW'(A) - p_q) == cur_r);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    row_d          = row_q;
    col_d          = col_q;
    bit_d          = bit_q;
    p_d            = p_q;
    cnt_d          = cnt_q;
    row_err_d      = row_err_q;
    col_err_d      = col_err_q;
    load_we        = 1'b0;
    fix_we         = 1'b0;
    mark_corr      = 1'b0;
    mark_uncorr    = 1'b0;
    adv            = 1'b0;
    bus.in_ready   = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_msg    = '0;
    bus.out_corr   = 1'b0;
    bus.out_uncorr = 1'b0;
    bus.out_last   = 1'b0;

    case (state_q)
      StLoad: begin
        bus.in_ready = !rst;
        if (bus.in_valid && !rst) begin
          load_we = 1'b1;
          if (bq_r != '0) begin
            row_err_d[row_q] = 1'b1;
            col_err_d[col_q] = 1'b1;
          end
          if (col_q == ColW'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + RowW'(1);
          end else begin
            col_d = col_q + ColW'(1);
          end
          if (last_idx) begin
            state_d = StScan;
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StScan: begin
        if (cur_r == '0) begin
          adv = 1'b1;
        end else if (cnt_q < CntW'(MAX_CORR)) begin
          state_d = StSearch;
          bit_d   = '0;
          p_d     = RW'(1);
        end else begin
          mark_uncorr = 1'b1;
          adv         = 1'b1;
        end
      end
      StSearch: begin
        if (match) begin
          fix_we    = 1'b1;
          mark_corr = 1'b1;
          cnt_d     = cnt_q + CntW'(1);
          adv       = 1'b1;
        end else if (bit_q == BitW'(CW_W - 1)) begin
          mark_uncorr = 1'b1;
          adv         = 1'b1;
        end else begin
          bit_d = bit_q + BitW'(1);
          p_d   = p_next;
        end
      end
      StDrain: begin
        bus.out_valid  = 1'b1;
        bus.out_msg    = bq_q[MSG_W-1:0];
        bus.out_corr   = corr_mem[idx_q] & ~q_ovf;
        bus.out_uncorr = uncorr_mem[idx_q] | q_ovf;
        bus.out_last   = last_idx;
        if (bus.out_ready) begin
          if (last_idx) begin
            state_d   = StLoad;
            idx_d     = '0;
            row_err_d = '0;
            col_err_d = '0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: state_d = StLoad;
    endcase

    // Move on to the next cell, or start draining after the last one.
    if (adv) begin
      if (last_idx) begin
        state_d = StDrain;
        idx_d   = '0;
      end else begin
        state_d = StScan;
        idx_d   = idx_q + IdxW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StLoad;
      idx_q     <= '0;
      row_q     <= '0;
      col_q     <= '0;
      bit_q     <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      row_err_q <= '0;
      col_err_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      row_q     <= row_d;
      col_q     <= col_d;
      bit_q     <= bit_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      row_err_q <= row_err_d;
      col_err_q <= col_err_d;
    end
  end

  // Frame buffer; per-cell flags are cleared as each cell is loaded.
  always_ff @(posedge clk) begin
    if (load_we) begin
      cw_mem[idx_q]     <= bus.in_cw;
      r_mem[idx_q]      <= bq_r;
      corr_mem[idx_q]   <= 1'b0;
      uncorr_mem[idx_q] <= 1'b0;
    end
    if (fix_we)      cw_mem[idx_q]     <= fix_cw;
    if (mark_corr)   corr_mem[idx_q]   <= 1'b1;
    if (mark_uncorr) uncorr_mem[idx_q] <= 1'b1;
  end

  assign row_err = row_err_q;
  assign col_err = col_err_q;

`ifdef AN_CORR_STATS_EN
  logic [15:0] stat_corr_q, stat_uncorr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_corr_q   <= '0;
      stat_uncorr_q <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      if (bus.out_corr && stat_corr_q != 16'hFFFF)     stat_corr_q   <= stat_corr_q + 16'd1;
      if (bus.out_uncorr && stat_uncorr_q != 16'hFFFF) stat_uncorr_q <= stat_uncorr_q + 16'd1;
    end
  end

  assign stat_corr   = stat_corr_q;
  assign stat_uncorr = stat_uncorr_q;
`endif

endmodule

// File: tb/tb_an_frame_corrector.sv
// Directed bench for an_frame_corrector (5x5 frame, A=29, MAX_CORR=2).
module tb_an_frame_corrector;
  localparam int N = 25;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  an_frame_corrector_if #(.CW_W(14), .MSG_W(10)) bus ();
  logic [4:0] row_err, col_err;
`ifdef AN_CORR_STATS_EN
  logic [15:0] stat_corr, stat_uncorr;
`endif

  an_frame_corrector #(.MAX_CORR(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .row_err (row_err),
    .col_err (col_err)
`ifdef AN_CORR_STATS_EN
    ,
    .stat_corr   (stat_corr),
    .stat_uncorr (stat_uncorr)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [13:0]  frame   [N];
  logic [9:0]   exp_msg [N];
  logic [9:0]   got_msg [N];
  logic [N-1:0] exp_corr, exp_uncorr, exp_last;
  logic [N-1:0] got_corr, got_uncorr, got_last;
  int           n_acc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Error-free frame of msg 10 (cw 290) with matching expectations.
  task automatic clean_frame();
    for (int i = 0; i < N; i++) begin
      frame[i]   = 14'd290;
      exp_msg[i] = 10'd10;
    end
    exp_corr   = '0;
    exp_uncorr = '0;
    exp_last   = '0;
    exp_last[N-1] = 1'b1;
  endtask

  task automatic send_beat(input logic [13:0] cw);
    int t = 0;
    bus.in_valid = 1'b1;
    bus.in_cw    = cw;
    while (!bus.in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) chk("in_ready timeout", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic collect(input bit toggle);
    int   cyc = 0;
    int   overlap = 0;
    int   hold_err = 0;
    bit   hold_pend = 0;
    logic [13:0] held = '0;
    logic [13:0] cur;
    n_acc      = 0;
    got_corr   = '0;
    got_uncorr = '0;
    got_last   = '0;
    for (int i = 0; i < N; i++) got_msg[i] = '0;
    while (n_acc < N && cyc < 1000) begin
      bus.out_ready = toggle ? ~cyc[0] : 1'b1;
      cur = {bus.out_valid, bus.out_msg, bus.out_corr, bus.out_uncorr, bus.out_last};
      if (hold_pend && cur !== held) hold_err++;
      hold_pend = 0;
      if (bus.out_valid && bus.in_ready) overlap++;
      if (bus.out_valid) begin
        if (bus.out_ready) begin
          got_msg[n_acc]    = bus.out_msg;
          got_corr[n_acc]   = bus.out_corr;
          got_uncorr[n_acc] = bus.out_uncorr;
          got_last[n_acc]   = bus.out_last;
          n_acc++;
        end else begin
          held      = cur;
          hold_pend = 1;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.out_ready = 1'b0;
    chk("accepts", n_acc, N);
    chk("in/out overlap", overlap, 0);
    if (toggle) chk("held while out_ready low", hold_err, 0);
  endtask

  task automatic run_frame(input string name, input bit toggle,
                           input logic [4:0] erow, input logic [4:0] ecol);
    for (int i = 0; i < N; i++) send_beat(frame[i]);
    chk({name, " row_err"}, {27'd0, row_err}, {27'd0, erow});
    chk({name, " col_err"}, {27'd0, col_err}, {27'd0, ecol});
    collect(toggle);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s cell%0d {msg,corr,uncorr,last}", name, i),
          {19'd0, got_msg[i], got_corr[i], got_uncorr[i], got_last[i]},
          {19'd0, exp_msg[i], exp_corr[i], exp_uncorr[i], exp_last[i]});
    chk({name, " idle after drain {out_valid,in_ready}"},
        {30'd0, bus.out_valid, bus.in_ready}, 32'd1);
  endtask

  initial begin
    int vcnt;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.out_ready = 1'b0;

    @(posedge clk); #1;
    chk("reset in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("reset out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset out_msg", {22'd0, bus.out_msg}, 32'd0);
    chk("reset row_err", {27'd0, row_err}, 32'd0);
    chk("reset col_err", {27'd0, col_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("in_ready after reset", {31'd0, bus.in_ready}, 32'd1);

    // 1) clean frame
    clean_frame();
    run_frame("t1", 1'b0, 5'b00000, 5'b00000);

    // 2) cell 7 = 298 (bit 3 set by the flip), row 1 col 2
    clean_frame();
    frame[7]    = 14'd298;
    exp_corr[7] = 1'b1;
    run_frame("t2", 1'b0, 5'b00010, 5'b00100);

    // 4) cell 0 = 37, multi-bit error: uncorrectable, raw q = 1
    clean_frame();
    frame[0]      = 14'd37;
    exp_msg[0]    = 10'd1;
    exp_uncorr[0] = 1'b1;
    run_frame("t4", 1'b0, 5'b00001, 5'b00001);

`ifdef AN_CORR_STATS_EN
    chk("stat_corr", {16'd0, stat_corr}, 32'd1);
    chk("stat_uncorr", {16'd0, stat_uncorr}, 32'd1);
`endif

    // 3) cell 24 = 34 (bit 8 cleared by the flip) restores 290
    clean_frame();
    frame[24]    = 14'd34;
    exp_corr[24] = 1'b1;
    run_frame("t3", 1'b0, 5'b10000, 5'b10000);

    // 5) three errors with MAX_CORR=2; out_ready toggles every cycle
    clean_frame();
    frame[3]       = 14'd298;
    frame[10]      = 14'd298;
    frame[20]      = 14'd298;
    exp_corr[3]    = 1'b1;
    exp_corr[10]   = 1'b1;
    exp_uncorr[20] = 1'b1;
    run_frame("t5", 1'b1, 5'b10101, 5'b01001);

    // 6) reset in the middle of loading discards the frame
    clean_frame();
    frame[5] = 14'd298;
    for (int i = 0; i < 12; i++) send_beat(frame[i]);
    chk("t6 row_err before reset", {27'd0, row_err}, 32'd2);
    rst = 1'b1;
    #1;
    chk("t6 in_ready during reset", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6 row_err after reset", {27'd0, row_err}, 32'd0);
    vcnt = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (bus.out_valid) vcnt++;
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    chk("t6 no out_valid after reset", vcnt, 0);
    clean_frame();
    run_frame("t6", 1'b0, 5'b00000, 5'b00000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
